mux_round_robin_arbiter: RTL and testbench
==========================================

# mux_round_robin_arbiter

Round-robin arbiter that shares the 4:1 multiplexer output channel among four requesters. Each requester raises a request line, the arbiter grants one at a time and drives the mux select (`addr1`,`addr0`). The granted input `inN` is routed to `out` for the duration of its grant. A hold counter caps each grant so no requester can starve the others. The block sits directly in front of the existing 4:1 mux datapath and replaces static select wiring.

## Interface
- `MAXHOLD`, default 4: maximum consecutive cycles one grant may be held; legal range 1..15.

- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset; sampled on rising edge of `clk`.
- `req0`..`req3` input 1 each: request lines; level-sensitive.
- `in0`..`in3` input 1 each: data inputs to the shared channel.
- `grant0`..`grant3` output 1 each: one-hot grant, registered; all 0 when idle.
- `addr0`, `addr1` output 1 each: registered mux select, {addr1,addr0} = index of granted requester.
- `valid` output 1: registered; 1 while any grant is active.
- `out` output 1: combinational, equals `in[{addr1,addr0}]` when `valid`=1, else 0.

## Operation
- State registers:
  - FSM state: IDLE or BUSY.
  - 2-bit priority pointer `ptr`.
  - 2-bit granted index `gidx`.
  - 4-bit hold counter `hcnt`.
- Reset values, effective on the edge where `reset`=1:
  - state=IDLE, `ptr`=0, `gidx`=0, `hcnt`=0.
  - grant0..3=0, addr1/addr0=00, `valid`=0, so `out`=0.
  - `reset` overrides all other inputs, including mid-grant.
- Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first asserted req wins.
- IDLE:
  - If any req=1: grant the pick, `gidx`=pick, addr=pick, `valid`=1, `hcnt`=1, go BUSY.
  - Otherwise remain IDLE with all outputs 0.
- BUSY, release condition: req[`gidx`]=0, OR `hcnt`==`MAXHOLD`.
  - On release: `ptr`=`gidx`+1 mod 4. In the same edge, re-arbitrate with the new `ptr` over current reqs:
    - Any req asserted: grant the pick immediately, with no idle cycle; `hcnt`=1; stay BUSY.
    - None asserted: go IDLE, clear grants, `valid`=0, addr=00.
  - No release: hold grant, addr and `valid`; `hcnt`=`hcnt`+1.
- The released requester has lowest priority at re-arbitration. If it is the only requester still asserting, it is re-granted: `valid` stays 1 and `hcnt` restarts at 1.
- Requests from non-granted requesters never disturb an active grant.
- A req pulse that drops before being granted is lost; requests are not latched.
- `hcnt` never exceeds `MAXHOLD`. With `MAXHOLD`=1, the grant rotates every cycle whenever multiple requesters are active.
- Exactly one grantN is high whenever `valid`=1. grant, addr and `valid` always change on the same edge.

## Timing
- Request-to-grant latency:
  - req asserted before edge N while IDLE: grant, addr and `valid` become visible after edge N (1 cycle).
  - While BUSY: latency to grant is bounded by 3×`MAXHOLD` cycles plus 1.
- Release latency: granted req drops before edge N, so the grant changes or clears after edge N. The granted requester's final grant cycle is the cycle in which its req is low.
- Forced release: a continuously requesting owner holds the grant exactly `MAXHOLD` cycles.
- `out` has zero-cycle combinational latency from `inN` and from the registered addr; there is no data pipelining.
- Reset asserted before edge N: all outputs are 0 after edge N. The first grant can occur on the first edge with `reset`=0.

## Test plan
- Reset with req0..3=1111 held high: outputs all 0 while `reset`=1. On the first edge after deassert: grant0=1, addr=00, `valid`=1.
- Single requester: req2=1 for 3 cycles, then 0, with in2 toggling 0/1 each cycle.
  - While granted: addr=10 and `out` tracks in2 cycle-by-cycle.
  - After the edge where req2=0 is sampled: `valid`=0, `out`=0, state IDLE.
- Fairness, all reqs=1 continuously with `MAXHOLD`=4: grants go 0,1,2,3,0, each held exactly 4 cycles. `valid` stays 1 with no gap cycles.
- Back-to-back handoff: req1=1 granted, req3 asserted mid-grant, then req1 dropped. grant3=1 and addr=11 on the very next edge, with `valid` never 0.
- Sole requester exceeds the cap: req0=1 held for 10 cycles with `MAXHOLD`=4.
  - Re-grant occurs at cycles 5 and 9, with `hcnt` restarting at 1; `valid` stays 1.
  - `ptr` is 1 after each release.
  - Asserting req1 afterwards wins at the next release.
- Reset mid-grant while grant3 is active and `hcnt`=2: all outputs 0 after the edge, `ptr`=0. With req0 and req3 both asserted afterwards, req0 wins the next grant.

Source files
------------

// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux channel.
// Each grant is capped at MAXHOLD cycles so that no requester can starve the others.
module mux_round_robin_arbiter #(
    parameter int MAXHOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic grant0,
    output logic grant1,
    output logic grant2,
    output logic grant3,
    output logic addr0,
    output logic addr1,
    output logic valid,
    output logic out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAXHOLD);

    state_t     state_r, state_nxt_s;
    logic [1:0] ptr_r, ptr_nxt_s;
    logic [1:0] gidx_r, gidx_nxt_s;
    logic [1:0] addr_r, addr_nxt_s;
    logic [3:0] hcnt_r, hcnt_nxt_s;
    logic [3:0] grant_r, grant_nxt_s;
    logic       valid_r, valid_nxt_s;

    logic [3:0] req_s;
    logic [3:0] in_s;
    logic [1:0] ptr_rel_s;
    logic       release_s;
    logic [2:0] pick_idle_s;
    logic [2:0] pick_rel_s;

    // Returns {found, index}: first asserted request scanning base, base+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] req);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign req_s       = {req3, req2, req1, req0};
    assign in_s        = {in3, in2, in1, in0};
    assign ptr_rel_s   = gidx_r + 2'd1;
    assign release_s   = (!req_s[gidx_r]) || (hcnt_r == HOLD_MAX);
    assign pick_idle_s = rr_pick(ptr_r, req_s);
    // Re-arbitration uses the pointer already advanced past the owner, so no idle cycle is needed.
    assign pick_rel_s  = rr_pick(ptr_rel_s, req_s);

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        gidx_nxt_s  = gidx_r;
        addr_nxt_s  = addr_r;
        hcnt_nxt_s  = hcnt_r;
        grant_nxt_s = grant_r;
        valid_nxt_s = valid_r;
        case (state_r)
            IDLE: begin
                if (pick_idle_s[2]) begin
                    state_nxt_s = BUSY;
                    gidx_nxt_s  = pick_idle_s[1:0];
                    addr_nxt_s  = pick_idle_s[1:0];
                    grant_nxt_s = 4'b0001 << pick_idle_s[1:0];
                    valid_nxt_s = 1'b1;
                    hcnt_nxt_s  = 4'd1;
                end else begin
                    grant_nxt_s = 4'b0000;
                    addr_nxt_s  = 2'b00;
                    valid_nxt_s = 1'b0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    ptr_nxt_s = ptr_rel_s;
                    if (pick_rel_s[2]) begin
                        gidx_nxt_s  = pick_rel_s[1:0];
                        addr_nxt_s  = pick_rel_s[1:0];
                        grant_nxt_s = 4'b0001 << pick_rel_s[1:0];
                        valid_nxt_s = 1'b1;
                        hcnt_nxt_s  = 4'd1;
                    end else begin
                        state_nxt_s = IDLE;
                        addr_nxt_s  = 2'b00;
                        grant_nxt_s = 4'b0000;
                        valid_nxt_s = 1'b0;
                        hcnt_nxt_s  = 4'd0;
                    end
                end else begin
                    hcnt_nxt_s = hcnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = 2'b00;
                gidx_nxt_s  = 2'b00;
                addr_nxt_s  = 2'b00;
                hcnt_nxt_s  = 4'd0;
                grant_nxt_s = 4'b0000;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= 2'b00;
            gidx_r  <= 2'b00;
            addr_r  <= 2'b00;
            hcnt_r  <= 4'd0;
            grant_r <= 4'b0000;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            gidx_r  <= gidx_nxt_s;
            addr_r  <= addr_nxt_s;
            hcnt_r  <= hcnt_nxt_s;
            grant_r <= grant_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign {grant3, grant2, grant1, grant0} = grant_r;
    assign {addr1, addr0}                   = addr_r;
    assign valid                            = valid_r;
    assign out                              = valid_r ? in_s[addr_r] : 1'b0;

endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Self-checking bench for mux_round_robin_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model of the arbitration rules.
module tb_mux_round_robin_arbiter;

    localparam int MAXHOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_v = 4'b0000;
    logic [3:0] in_v = 4'b0000;
    logic req0, req1, req2, req3, in0, in1, in2, in3;
    logic grant0, grant1, grant2, grant3, addr0, addr1, valid, out;

    int compared = 0;
    int mismatched = 0;

    // Reference model: who owns the channel, for how long, and who is first in line.
    int m_busy = 0;
    int m_ptr = 0;
    int m_owner = 0;
    int m_held = 0;

    assign {req3, req2, req1, req0} = req_v;
    assign {in3, in2, in1, in0}     = in_v;

    always #5 clk = ~clk;

    mux_round_robin_arbiter #(.MAXHOLD(MAXHOLD)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .req2(req2), .req3(req3),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .grant0(grant0), .grant1(grant1), .grant2(grant2), .grant3(grant3),
        .addr0(addr0), .addr1(addr1), .valid(valid), .out(out)
    );

    function automatic int winner(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic [3:0] r);
        int w;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_owner = 0; m_held = 0;
        end else if (m_busy == 0) begin
            w = winner(m_ptr, r);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_held = 1;
            end
        end else if (!r[m_owner] || m_held == MAXHOLD) begin
            m_ptr = (m_owner + 1) % 4;
            w = winner(m_ptr, r);
            if (w >= 0) begin
                m_owner = w; m_held = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_held++;
        end
    endtask

    function automatic logic [3:0] exp_grant();
        return (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    function automatic logic exp_out();
        return (m_busy != 0) ? in_v[m_owner] : 1'b0;
    endfunction

    // One clock: drive at the falling edge, update the model at the rising edge, check 1 ns later.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] i);
        @(negedge clk);
        reset = rst; req_v = r; in_v = i;
        @(posedge clk);
        model_update(rst, r);
        #1;
        check("grant", {grant3, grant2, grant1, grant0}, exp_grant());
        check("addr", {2'b00, addr1, addr0}, (m_busy != 0) ? 4'(m_owner) : 4'b0000);
        check("valid", {3'b000, valid}, {3'b000, (m_busy != 0)});
        check("out", {3'b000, out}, {3'b000, exp_out()});
        in_v = ~in_v;
        #1;
        check("out_comb", {3'b000, out}, {3'b000, exp_out()});
    endtask

    initial begin
        // Reset while every requester is asserting, then release.
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b1111, 4'b1111);
        check("reset_grant", {grant3, grant2, grant1, grant0}, 4'b0000);
        step(1'b0, 4'b1111, 4'b0000);
        check("first_grant", {grant3, grant2, grant1, grant0}, 4'b0001);

        // Single requester 2 with in2 toggling, then release to idle.
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, (c % 2 == 0) ? 4'b0100 : 4'b0000);
        step(1'b0, 4'b0000, 4'b0100);
        check("single_idle", {3'b000, valid}, 4'b0000);

        // Fairness with everybody requesting.
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 20; c++) step(1'b0, 4'b1111, 4'(c));

        // Back-to-back handoff from requester 1 to requester 3.
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0010, 4'b0010);
        step(1'b0, 4'b0010, 4'b0000);
        step(1'b0, 4'b1010, 4'b1010);
        step(1'b0, 4'b1000, 4'b1000);
        check("handoff", {grant3, grant2, grant1, grant0}, 4'b1000);
        step(1'b0, 4'b1000, 4'b0000);

        // Sole requester exceeding the cap, then requester 1 joins.
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 10; c++) step(1'b0, 4'b0001, 4'b0001);
        for (int c = 0; c < 6; c++) step(1'b0, 4'b0011, 4'b0011);

        // Reset during requester 3's grant, then 0 and 3 compete.
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1000, 4'b1000);
        step(1'b0, 4'b1000, 4'b1000);
        step(1'b1, 4'b1000, 4'b1000);
        step(1'b0, 4'b1001, 4'b1001);
        check("post_reset_pick", {grant3, grant2, grant1, grant0}, 4'b0001);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
